// File: rtl/operand_skew_buffer_pkg.sv
// Shared constants for the operand skew buffer: default array size, element width
// and the packed width of one lane slice travelling down a delay line.
package operand_skew_buffer_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 8;

    // One lane slice is {valid, b_element, a_element}.
    localparam int LANE_W = 2 * DEF_DW + 1;

    function automatic int lane_slice_w(input int dw);
        return 2 * dw + 1;
    endfunction

endpackage

// File: rtl/operand_skew_buffer_lane_delay.sv
// Fixed-depth shift register carrying one lane slice; q is d delayed by DEPTH cycles.
// clr is a synchronous active-high clear of every stage.
module lane_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          clr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/operand_skew_buffer.sv
// N-entry operand FIFO feeding a triangular skew stage: lane i of each popped A/B
// entry reaches the array edge i+1 cycles after the pop, with per-lane valid.
module operand_skew_buffer
    import operand_skew_buffer_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            buff_rst_n,
    input  logic            buff_wr,
    input  logic            buff_rd,
    input  logic [N*DW-1:0] s_axis_a,
    input  logic [N*DW-1:0] s_axis_b,
    output logic            buff_is_full,
    output logic            buff_is_empty,
    output logic [N*DW-1:0] arr_a,
    output logic [N*DW-1:0] arr_b,
    output logic [N-1:0]    arr_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int SW = lane_slice_w(DW);

    // Push/pop protocol: buff_wr is accepted when not full, or when full but a pop
    // happens in the same cycle; buff_rd pops only when not empty, otherwise it
    // injects a bubble. Neither side is back-pressured beyond that.
    logic [N*DW-1:0] mem_a [N];
    logic [N*DW-1:0] mem_b [N];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic            full_q, empty_q;
    logic            clr, do_push, do_pop;
    logic [N*DW-1:0] inj_a, inj_b;
    logic [SW-1:0]   lane_q [N];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign clr     = ~i_rst_n | ~buff_rst_n;
    assign do_pop  = buff_rd & ~empty_q;
    assign do_push = buff_wr & (~full_q | do_pop);

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_nxt;
            full_q  <= (count_nxt == CW'(N));
            empty_q <= (count_nxt == '0);
        end
    end

    // Storage is not reset; it is only read on a pop, i.e. after being written.
    always_ff @(posedge i_clk) begin
        if (do_push && !clr) begin
            mem_a[wr_ptr] <= s_axis_a;
            mem_b[wr_ptr] <= s_axis_b;
        end
    end

    assign inj_a = do_pop ? mem_a[rd_ptr] : '0;
    assign inj_b = do_pop ? mem_b[rd_ptr] : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        lane_delay #(
            .DEPTH (gi + 1),
            .DW    (SW)
        ) u_lane (
            .i_clk (i_clk),
            .clr   (clr),
            .d     ({do_pop, inj_b[gi*DW +: DW], inj_a[gi*DW +: DW]}),
            .q     (lane_q[gi])
        );
        assign arr_valid[gi]       = lane_q[gi][SW-1];
        assign arr_b[gi*DW +: DW]  = lane_q[gi][2*DW-1:DW];
        assign arr_a[gi*DW +: DW]  = lane_q[gi][DW-1:0];
    end

    assign buff_is_full  = full_q;
    assign buff_is_empty = empty_q;

endmodule

// File: tb/tb_operand_skew_buffer.sv
// Directed bench for operand_skew_buffer: an N=4 instance for fill/drain/reset
// cases and an N=3 instance for pointer wrap against a FIFO model.
module tb_operand_skew_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_n, brst4, brst3;
    logic        wr4, rd4, wr3, rd3;
    logic [31:0] a4, b4, arr_a4, arr_b4;
    logic [23:0] a3, b3, arr_a3, arr_b3;
    logic        full4, empty4, full3, empty3;
    logic [3:0]  valid4;
    logic [2:0]  valid3;

    operand_skew_buffer #(.N(4), .DW(8)) u_dut4 (
        .i_clk (clk), .i_rst_n (rst_n), .buff_rst_n (brst4),
        .buff_wr (wr4), .buff_rd (rd4), .s_axis_a (a4), .s_axis_b (b4),
        .buff_is_full (full4), .buff_is_empty (empty4),
        .arr_a (arr_a4), .arr_b (arr_b4), .arr_valid (valid4)
    );

    operand_skew_buffer #(.N(3), .DW(8)) u_dut3 (
        .i_clk (clk), .i_rst_n (rst_n), .buff_rst_n (brst3),
        .buff_wr (wr3), .buff_rd (rd3), .s_axis_a (a3), .s_axis_b (b3),
        .buff_is_full (full3), .buff_is_empty (empty3),
        .arr_a (arr_a3), .arr_b (arr_b3), .arr_valid (valid3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle4(input string tag);
        check({tag, "_empty"}, 64'(empty4), 64'd1);
        check({tag, "_full"},  64'(full4),  64'd0);
        check({tag, "_valid"}, 64'(valid4), 64'd0);
        check({tag, "_arr_a"}, 64'(arr_a4), 64'd0);
        check({tag, "_arr_b"}, 64'(arr_b4), 64'd0);
    endtask

    // N=3 scoreboard: FIFO model plus a history of injected slices (index = age).
    logic [47:0] exp_q[$];
    logic [47:0] popped;
    logic        hv [3];
    logic [23:0] ha [3];
    logic [23:0] hb [3];
    logic [0:20] wr_pat = 21'b111101101111010000000;
    logic [0:20] rd_pat = 21'b000011011101101111000;

    initial begin
        rst_n = 1'b0; brst4 = 1'b1; brst3 = 1'b1;
        wr4 = 1'b1; rd4 = 1'b0; wr3 = 1'b1; rd3 = 1'b0;
        a4 = 32'h11223344; b4 = 32'h55667788; a3 = 24'h112233; b3 = 24'h445566;

        // Reset with pushes requested: pushes must be discarded.
        tick(); tick();
        check_idle4("reset");
        check("reset_empty3", 64'(empty3), 64'd1);
        wr4 = 1'b0; wr3 = 1'b0; rst_n = 1'b1;
        tick();
        check_idle4("post_reset");

        // Fill with four identical entries, then an overflow push.
        a4 = 32'h04030201; b4 = 32'h08070605; wr4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("fill%0d_full", k), 64'(full4), 64'(k == 4));
            check($sformatf("fill%0d_empty", k), 64'(empty4), 64'd0);
        end
        a4 = 32'hdeadbeef; b4 = 32'hcafef00d;
        tick();
        check("overflow_full", 64'(full4), 64'd1);
        wr4 = 1'b0;

        // Drain: lane i valid k in [i+1, i+4] ticks after the first pop edge.
        for (int k = 1; k <= 8; k++) begin
            rd4 = (k <= 4);
            tick();
            check($sformatf("drain%0d_empty", k), 64'(empty4), 64'(k >= 4));
            for (int i = 0; i < 4; i++) begin
                logic v;
                v = (k >= i + 1) && (k <= i + 4);
                check($sformatf("drain%0d_v%0d", k, i), 64'(valid4[i]), 64'(v));
                check($sformatf("drain%0d_a%0d", k, i), 64'(arr_a4[i*8 +: 8]), v ? 64'(i + 1) : 64'd0);
                check($sformatf("drain%0d_b%0d", k, i), 64'(arr_b4[i*8 +: 8]), v ? 64'(i + 5) : 64'd0);
            end
        end

        // Reads while empty inject only bubbles.
        rd4 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_idle4($sformatf("bubble%0d", k));
        end
        rd4 = 1'b0;

        // Full, then simultaneous push+pop: newest entry comes out last.
        wr4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a4 = 32'h40404040 + k * 32'h01010101;
            b4 = 32'h80808080 + k * 32'h01010101;
            tick();
        end
        a4 = 32'h44444444; b4 = 32'h84848484; rd4 = 1'b1;
        tick();
        check("wrrd_full", 64'(full4), 64'd1);
        check("wrrd_v0", 64'(valid4[0]), 64'd1);
        check("wrrd_a0", 64'(arr_a4[7:0]), 64'h40);
        wr4 = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("wrrd_pop%0d_v0", j), 64'(valid4[0]), 64'd1);
            check($sformatf("wrrd_pop%0d_a0", j), 64'(arr_a4[7:0]), 64'(8'h40 + j));
            check($sformatf("wrrd_pop%0d_b0", j), 64'(arr_b4[7:0]), 64'(8'h80 + j));
        end
        check("wrrd_empty", 64'(empty4), 64'd1);
        rd4 = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        // Mid-operation clear with data in flight and a push requested.
        a4 = 32'h0a0b0c0d; b4 = 32'h01020304; wr4 = 1'b1;
        tick(); tick(); tick();
        wr4 = 1'b0; rd4 = 1'b1;
        tick();
        rd4 = 1'b0; wr4 = 1'b1; brst4 = 1'b0;
        tick();
        check_idle4("buff_clr");
        brst4 = 1'b1; wr4 = 1'b0;
        tick();
        check_idle4("post_clr");

        // N=3 interleaved traffic against the model.
        for (int i = 0; i < 3; i++) begin
            hv[i] = 1'b0; ha[i] = '0; hb[i] = '0;
        end
        for (int k = 0; k < 21; k++) begin
            logic pop_ok, push_ok;
            wr3 = wr_pat[k]; rd3 = rd_pat[k];
            a3 = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
            b3 = {8'(8'hc0 + k), 8'(8'hb0 + k), 8'(8'ha0 + k)};
            pop_ok  = rd3 && (exp_q.size() > 0);
            push_ok = wr3 && ((exp_q.size() < 3) || pop_ok);
            tick();
            popped = '0;
            if (pop_ok)  popped = exp_q.pop_front();
            if (push_ok) exp_q.push_back({b3, a3});
            for (int i = 2; i > 0; i--) begin
                hv[i] = hv[i-1]; ha[i] = ha[i-1]; hb[i] = hb[i-1];
            end
            hv[0] = pop_ok; ha[0] = popped[23:0]; hb[0] = popped[47:24];
            check($sformatf("n3_c%0d_empty", k), 64'(empty3), 64'(exp_q.size() == 0));
            check($sformatf("n3_c%0d_full", k), 64'(full3), 64'(exp_q.size() == 3));
            for (int i = 0; i < 3; i++) begin
                check($sformatf("n3_c%0d_v%0d", k, i), 64'(valid3[i]), 64'(hv[i]));
                check($sformatf("n3_c%0d_a%0d", k, i), 64'(arr_a3[i*8 +: 8]), 64'(ha[i][i*8 +: 8]));
                check($sformatf("n3_c%0d_b%0d", k, i), 64'(arr_b3[i*8 +: 8]), 64'(hb[i][i*8 +: 8]));
            end
        end
        wr3 = 1'b0; rd3 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_skew_buffer.md
OPERAND_SKEW_BUFFER -- requirements
Module: operand_skew_buffer

Interface
REQ-001 Parameter N, default 4, systolic array dimension: lanes per operand and buffer depth in entries.
REQ-002 Parameter DW, default 8, bits per operand element.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  synchronous active-low reset.
REQ-005 buff_rst_n  input  1  synchronous active-low clear from the array controller.
REQ-006 buff_wr  input  1  push one entry.
REQ-007 buff_rd  input  1  pop one entry into the skew lines.
REQ-008 s_axis_a  input  N*DW  A-row elements; lane i occupies bits [i*DW +: DW].
REQ-009 s_axis_b  input  N*DW  B-column elements; same lane packing as s_axis_a.
REQ-010 buff_is_full  output  1  high when count == N.
REQ-011 buff_is_empty  output  1  high when count == 0.
REQ-012 arr_a  output  N*DW  skewed A lanes to the array west edge.
REQ-013 arr_b  output  N*DW  skewed B lanes to the array north edge.
REQ-014 arr_valid  output  N  per-lane valid qualifying arr_a/arr_b lane i.

Function
REQ-015 Storage SHALL be an N-entry circular FIFO with write pointer, read pointer and count; count width SHALL be $clog2(N+1).
REQ-016 Pointers SHALL wrap from N-1 to 0, including when N is not a power of two.
REQ-017 A push SHALL occur on a cycle with buff_wr=1 and (buff_is_full=0 or a pop in the same cycle).
REQ-018 A pop SHALL occur on a cycle with buff_rd=1 and buff_is_empty=0; no bypass when empty.
REQ-019 buff_wr while full without a pop SHALL be dropped with no state change.
REQ-020 buff_rd while empty SHALL be ignored for the FIFO and SHALL inject a bubble.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Flags SHALL be registered and consistent with count after each edge.
REQ-023 Each cycle the block SHALL inject into the skew stage either the popped entry with valid=1 or zeros with valid=0.
REQ-024 Lane i SHALL delay its injected A element, B element and valid by exactly i+1 cycles.
REQ-025 Skew lines SHALL shift every cycle regardless of buff_rd, so zeros drain behind the last entry.
REQ-026 Bubble lanes SHALL present all-zero data with arr_valid[i]=0.

Reset
REQ-027 On i_rst_n=0: pointers, count and all skew stages SHALL clear; buff_is_empty=1, buff_is_full=0, arr_a=0, arr_b=0, arr_valid=0.
REQ-028 buff_rst_n=0 SHALL have the identical effect as i_rst_n=0, including mid-operation.
REQ-029 Push or pop in a cycle where either reset is low SHALL be discarded.
REQ-030 FIFO storage contents SHALL need no reset; outputs SHALL never expose unreset storage.

Structure
REQ-031 A shared package SHALL hold default N and DW, and the lane-slice width constant.
REQ-032 The per-lane delay line SHALL be a sub-module lane_delay with parameters DEPTH and DW, instantiated with DEPTH=i+1 per lane.
REQ-033 The block SHALL contain no combinational path from inputs to arr_a, arr_b or arr_valid.

Verification
REQ-034 Reset, then 4 pushes of A=0x04030201, B=0x08070605 -> full=1, empty=0 after the 4th edge; a 5th push is dropped and count stays 4.
REQ-035 From full, assert buff_rd for 4 cycles, first pop at cycle t -> arr_valid[0] high in cycles t+1..t+4; arr_valid[3] high in cycles t+4..t+7; arr_a lane 3 = 0x04 in each of those cycles; empty=1 after the 4th pop.
REQ-036 From empty, assert buff_rd=1 for 3 cycles -> arr_valid stays 0, arr_a and arr_b stay 0, empty stays 1.
REQ-037 From count=4, assert buff_wr and buff_rd together -> count stays 4, and the new entry is popped after the 4 older ones.
REQ-038 Push 3 entries, pop 1, then drive buff_rst_n=0 for 1 cycle -> the next edge gives empty=1, arr_valid=0, and arr_a and arr_b all zero.
REQ-039 Run 10 pushes interleaved with pops at N=3 -> pointers wrap 2->0 and the output order matches a scoreboard model.
